// File: rtl/nios_system_mem_copier_pkg.sv
// Shared types for the on-chip memory copy/fill master.
// State encoding and command mode constants.
package nios_system_mem_copier_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_WAIT,
      S_WR_REQ,
      S_DONE
   } state_e;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/nios_system_mem_copier.sv
// Avalon-MM master copying or filling word ranges of an
// on-chip memory, one transaction at a time.
module nios_system_mem_copier
   import nios_system_mem_copier_pkg::*;
#(
   parameter int ADDR_W       = 3,
   parameter int DATA_W       = 16,
   parameter int LEN_W        = ADDR_W + 1,
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                mode,
   input  logic [ADDR_W-1:0]   src_addr,
   input  logic [ADDR_W-1:0]   dst_addr,
   input  logic [LEN_W-1:0]    length,
   input  logic [DATA_W-1:0]   fill_data,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   avm_address,
   output logic                avm_chipselect,
   output logic                avm_read,
   output logic                avm_write,
   output logic [DATA_W/8-1:0] avm_byteenable,
   output logic [DATA_W-1:0]   avm_writedata,
   output logic                avm_clken,
   input  logic [DATA_W-1:0]   avm_readdata,
   input  logic                avm_waitrequest
);

   localparam int BE_W = DATA_W / 8;

   state_e              state_q, state_d;
   logic                mode_q, mode_d;
   logic [ADDR_W-1:0]   src_q, src_d;
   logic [ADDR_W-1:0]   dst_q, dst_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          lat_q, lat_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [DATA_W-1:0]   fill_q, fill_d;

   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                rd_q, rd_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;

   // Next state, and bus outputs precomputed from it so they leave a flop
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      lat_d   = lat_q;
      data_d  = data_q;
      fill_d  = fill_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d = mode;
               src_d  = src_addr;
               dst_d  = dst_addr;
               cnt_d  = length;
               fill_d = fill_data;
               if (length == '0)
                  state_d = S_DONE;
               else if (mode == MODE_FILL)
                  state_d = S_WR_REQ;
               else
                  state_d = S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            if (!avm_waitrequest) begin
               lat_d   = 2'(READ_LATENCY);
               state_d = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (lat_q == 2'd1) begin
               data_d  = avm_readdata;
               state_d = S_WR_REQ;
            end else begin
               lat_d = lat_q - 2'd1;
            end
         end
         S_WR_REQ: begin
            if (!avm_waitrequest) begin
               src_d = src_q + 1'b1;
               dst_d = dst_q + 1'b1;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == LEN_W'(1))
                  state_d = S_DONE;
               else if (mode_q == MODE_COPY)
                  state_d = S_RD_REQ;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
      rd_d    = (state_d == S_RD_REQ);
      wr_d    = (state_d == S_WR_REQ);
      addr_d  = rd_d ? src_d : (wr_d ? dst_d : '0);
      wdata_d = '0;
      if (wr_d)
         wdata_d = (mode_d == MODE_FILL) ? fill_d : data_d;
   end

   // State, command registers and registered bus outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         mode_q  <= MODE_COPY;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         lat_q   <= '0;
         data_q  <= '0;
         fill_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
         data_q  <= data_d;
         fill_q  <= fill_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign avm_read       = rd_q;
   assign avm_write      = wr_q;
   assign avm_chipselect = rd_q | wr_q;
   assign avm_byteenable = {BE_W{rd_q | wr_q}};
   assign avm_address    = addr_q;
   assign avm_writedata  = wdata_q;
   assign avm_clken      = 1'b1;

endmodule

// File: tb/tb_nios_system_mem_copier.sv
// Bench for the memory copier: 8-word latency-1 slave model plus
// a loop-based reference of the copy/fill result.
module tb_nios_system_mem_copier;

   localparam int AW = 3;
   localparam int DW = 16;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          reset, start, mode;
   logic [AW-1:0] src_addr, dst_addr;
   logic [LW-1:0] length;
   logic [DW-1:0] fill_data;
   logic          busy, done;
   logic [AW-1:0] avm_address;
   logic          avm_chipselect, avm_read, avm_write;
   logic [1:0]    avm_byteenable;
   logic [DW-1:0] avm_writedata;
   logic          avm_clken;
   logic [DW-1:0] avm_readdata;
   logic          avm_waitrequest;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] mem [8];
   logic [DW-1:0] ref_mem [8];
   logic [DW-1:0] rd_q;
   logic          ld_en;
   logic [AW-1:0] ld_a;
   logic [DW-1:0] ld_d;

   int nrd, nwr, ndone, busy_cyc, done_at, nstall, nstrobe, nunstable;
   int waddr[$];

   nios_system_mem_copier dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
      .fill_data(fill_data), .busy(busy), .done(done),
      .avm_address(avm_address), .avm_chipselect(avm_chipselect),
      .avm_read(avm_read), .avm_write(avm_write),
      .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
      .avm_clken(avm_clken), .avm_readdata(avm_readdata),
      .avm_waitrequest(avm_waitrequest)
   );

   always #5 clk = ~clk;

   // On-chip memory slave: single-cycle write, read latency 1
   always @(posedge clk) begin
      if (ld_en)
         mem[ld_a] <= ld_d;
      else if (avm_chipselect && avm_write && !avm_waitrequest)
         mem[avm_address] <= avm_writedata;
      if (avm_chipselect && avm_read && !avm_waitrequest)
         rd_q <= mem[avm_address];
   end
   assign avm_readdata = rd_q;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input bit rnd);
      for (int i = 0; i < 8; i++) begin
         ld_en = 1'b1;
         ld_a  = AW'(i);
         ld_d  = rnd ? DW'($urandom) : DW'(16'h1000 + i);
         ref_mem[i] = ld_d;
         cyc();
      end
      ld_en = 1'b0;
   endtask

   // Reference: words moved in ascending order, addresses mod 8
   task automatic ref_cmd(input logic m, input int s, input int d,
                          input int l, input logic [DW-1:0] f);
      for (int k = 0; k < l; k++)
         ref_mem[(d + k) % 8] = m ? f : ref_mem[(s + k) % 8];
   endtask

   task automatic run(input logic m, input int s, input int d,
                      input int l, input logic [DW-1:0] f,
                      input int stall_pct, input int restart_at);
      logic           hold;
      logic [AW+DW+1:0] hold_v;
      waddr.delete();
      nrd = 0; nwr = 0; ndone = 0; busy_cyc = 0; done_at = -1;
      nstall = 0; nstrobe = 0; nunstable = 0; hold = 1'b0; hold_v = '0;
      mode = m; src_addr = AW'(s); dst_addr = AW'(d);
      length = LW'(l); fill_data = f;
      start = 1'b1; avm_waitrequest = 1'b0;
      cyc();
      start = 1'b0;
      for (int c = 1; c <= 400; c++) begin
         if (c == restart_at) begin
            start = 1'b1; mode = ~m; dst_addr = AW'(d + 3);
            length = LW'(1); fill_data = ~f;
         end else begin
            start = 1'b0;
         end
         if (hold && ({avm_read, avm_write, avm_address, avm_writedata} !== hold_v))
            nunstable++;
         avm_waitrequest = (stall_pct > 0) && (int'($urandom_range(99)) < stall_pct);
         hold   = (avm_read || avm_write) && avm_waitrequest;
         hold_v = {avm_read, avm_write, avm_address, avm_writedata};
         if (avm_read || avm_write) nstrobe++;
         if (hold) nstall++;
         if (avm_read && !avm_waitrequest) nrd++;
         if (avm_write && !avm_waitrequest) begin
            nwr++;
            waddr.push_back(int'(avm_address));
         end
         if (busy && !done) busy_cyc++;
         if (done) begin
            ndone++;
            if (done_at < 0) done_at = c;
         end
         cyc();
         if (done_at >= 0) break;
      end
      start = 1'b0;
      avm_waitrequest = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc(); cyc();
      total++;
      if ({busy, done, avm_read, avm_write, avm_chipselect} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctl got %b want 00000",
                  {busy, done, avm_read, avm_write, avm_chipselect});
      end
      total++;
      if ({avm_address, avm_writedata, avm_byteenable} !== '0) begin
         bad++;
         $display("FAIL reset_bus got %h/%h/%b want 0",
                  avm_address, avm_writedata, avm_byteenable);
      end
      total++;
      if (avm_clken !== 1'b1) begin
         bad++;
         $display("FAIL reset_clken got %b want 1", avm_clken);
      end
      reset = 1'b0;
      cyc();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_busy got %b want 0", busy);
      end
   endtask

   task automatic test_fill();
      preload(1'b1);
      ref_cmd(1'b1, 0, 2, 4, 16'hBEEF);
      run(1'b1, 0, 2, 4, 16'hBEEF, 0, 0);
      total++;
      if (done_at != 5) begin
         bad++; $display("FAIL fill_done_at got %0d want 5", done_at);
      end
      total++;
      if (nwr != 4 || nrd != 0 || busy_cyc != 4) begin
         bad++;
         $display("FAIL fill_counts got wr=%0d rd=%0d busy=%0d want 4 0 4",
                  nwr, nrd, busy_cyc);
      end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (k >= waddr.size() || waddr[k] != 2 + k) begin
            bad++; $display("FAIL fill_addr%0d got size %0d want %0d", k, waddr.size(), 2 + k);
         end
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (mem[i] !== ref_mem[i]) begin
            bad++; $display("FAIL fill_mem%0d got %h want %h", i, mem[i], ref_mem[i]);
         end
      end
   endtask

   task automatic test_copy();
      preload(1'b0);
      ref_cmd(1'b0, 0, 4, 3, '0);
      run(1'b0, 0, 4, 3, 16'h5555, 0, 0);
      total++;
      if (nrd != 3 || nwr != 3) begin
         bad++; $display("FAIL copy_counts got rd=%0d wr=%0d want 3 3", nrd, nwr);
      end
      total++;
      if (busy_cyc != 9 || done_at != 10) begin
         bad++;
         $display("FAIL copy_timing got busy=%0d done_at=%0d want 9 10", busy_cyc, done_at);
      end
      total++;
      if (mem[4] !== 16'h1000 || mem[5] !== 16'h1001 || mem[6] !== 16'h1002) begin
         bad++;
         $display("FAIL copy_words got %h %h %h want 1000 1001 1002", mem[4], mem[5], mem[6]);
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (mem[i] !== ref_mem[i]) begin
            bad++; $display("FAIL copy_mem%0d got %h want %h", i, mem[i], ref_mem[i]);
         end
      end
   endtask

   task automatic test_wrap();
      int exp_a[4] = '{6, 7, 0, 1};
      preload(1'b1);
      ref_cmd(1'b1, 0, 6, 4, 16'h00AA);
      run(1'b1, 3, 6, 4, 16'h00AA, 0, 0);
      for (int k = 0; k < 4; k++) begin
         total++;
         if (k >= waddr.size() || waddr[k] != exp_a[k]) begin
            bad++; $display("FAIL wrap_addr%0d got size %0d want %0d", k, waddr.size(), exp_a[k]);
         end
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (mem[i] !== ref_mem[i]) begin
            bad++; $display("FAIL wrap_mem%0d got %h want %h", i, mem[i], ref_mem[i]);
         end
      end
   endtask

   task automatic test_stall();
      int s, d;
      preload(1'b1);
      s = int'($urandom_range(7));
      d = int'($urandom_range(7));
      ref_cmd(1'b0, s, d, 8, '0);
      run(1'b0, s, d, 8, 16'h0, 40, 0);
      total++;
      if (nunstable != 0) begin
         bad++; $display("FAIL stall_stable got %0d changes want 0", nunstable);
      end
      total++;
      if (ndone != 1 || nrd != 8 || nwr != 8) begin
         bad++;
         $display("FAIL stall_counts got done=%0d rd=%0d wr=%0d want 1 8 8", ndone, nrd, nwr);
      end
      total++;
      if (busy_cyc != 24 + nstall) begin
         bad++; $display("FAIL stall_cycles got %0d want %0d", busy_cyc, 24 + nstall);
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (mem[i] !== ref_mem[i]) begin
            bad++; $display("FAIL stall_mem%0d got %h want %h", i, mem[i], ref_mem[i]);
         end
      end
   endtask

   task automatic test_zero_len();
      run(1'b0, 1, 2, 0, 16'h1234, 0, 0);
      total++;
      if (done_at != 1 || nstrobe != 0 || busy_cyc != 0) begin
         bad++;
         $display("FAIL zero_len got done_at=%0d strobes=%0d busy=%0d want 1 0 0",
                  done_at, nstrobe, busy_cyc);
      end
   endtask

   task automatic test_restart_ignored();
      preload(1'b1);
      ref_cmd(1'b1, 0, 0, 6, 16'h1111);
      run(1'b1, 0, 0, 6, 16'h1111, 0, 2);
      total++;
      if (nwr != 6 || done_at != 7) begin
         bad++; $display("FAIL restart got wr=%0d done_at=%0d want 6 7", nwr, done_at);
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (mem[i] !== ref_mem[i]) begin
            bad++; $display("FAIL restart_mem%0d got %h want %h", i, mem[i], ref_mem[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      preload(1'b1);
      ref_cmd(1'b1, 0, 1, 3, 16'hA5A5);
      ref_cmd(1'b0, 1, 5, 3, '0);
      run(1'b1, 0, 1, 3, 16'hA5A5, 0, 0);
      run(1'b0, 1, 5, 3, 16'h0, 0, 0);
      total++;
      if (done_at != 10 || nwr != 3) begin
         bad++; $display("FAIL b2b got done_at=%0d wr=%0d want 10 3", done_at, nwr);
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (mem[i] !== ref_mem[i]) begin
            bad++; $display("FAIL b2b_mem%0d got %h want %h", i, mem[i], ref_mem[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int  w, dn;
      bit  hit;
      preload(1'b1);
      mode = 1'b0; src_addr = 3'd0; dst_addr = 3'd3; length = 4'd5;
      start = 1'b1; avm_waitrequest = 1'b0;
      cyc();
      start = 1'b0;
      w = 0; hit = 1'b0;
      for (int c = 0; c < 60 && !hit; c++) begin
         if (avm_write && w == 1) begin
            avm_waitrequest = 1'b1; reset = 1'b1; hit = 1'b1;
         end else if (avm_write) begin
            w++;
         end
         cyc();
      end
      reset = 1'b0; avm_waitrequest = 1'b0;
      ref_cmd(1'b0, 0, 3, 1, '0);
      total++;
      if (!hit) begin
         bad++; $display("FAIL rst_mid_reach got no second write want one");
      end
      total++;
      if ({avm_read, avm_write, avm_chipselect, busy} !== 4'b0) begin
         bad++;
         $display("FAIL rst_mid_strobes got %b want 0000",
                  {avm_read, avm_write, avm_chipselect, busy});
      end
      dn = 0;
      for (int c = 0; c < 12; c++) begin
         if (done) dn++;
         cyc();
      end
      total++;
      if (dn != 0) begin
         bad++; $display("FAIL rst_mid_done got %0d pulses want 0", dn);
      end
      ref_cmd(1'b0, 2, 6, 4, '0);
      run(1'b0, 2, 6, 4, 16'h0, 0, 0);
      total++;
      if (done_at != 13 || ndone != 1) begin
         bad++; $display("FAIL rst_mid_rerun got done_at=%0d want 13", done_at);
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (mem[i] !== ref_mem[i]) begin
            bad++; $display("FAIL rst_mid_mem%0d got %h want %h", i, mem[i], ref_mem[i]);
         end
      end
   endtask

   task automatic test_random();
      logic        m;
      int          s, d, l, p;
      logic [DW-1:0] f;
      for (int t = 0; t < 6; t++) begin
         m = 1'($urandom_range(1));
         s = int'($urandom_range(7));
         d = int'($urandom_range(7));
         l = int'($urandom_range(8));
         p = int'($urandom_range(50));
         f = DW'($urandom);
         ref_cmd(m, s, d, l, f);
         run(m, s, d, l, f, p, 0);
         total++;
         if (ndone != 1 || nwr != l || busy_cyc != l * (m ? 1 : 3) + nstall) begin
            bad++;
            $display("FAIL rand%0d got done=%0d wr=%0d busy=%0d want 1 %0d %0d",
                     t, ndone, nwr, busy_cyc, l, l * (m ? 1 : 3) + nstall);
         end
         for (int i = 0; i < 8; i++) begin
            total++;
            if (mem[i] !== ref_mem[i]) begin
               bad++; $display("FAIL rand%0d_mem%0d got %h want %h", t, i, mem[i], ref_mem[i]);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mode = 1'b0;
      src_addr = '0; dst_addr = '0; length = '0; fill_data = '0;
      avm_waitrequest = 1'b0; ld_en = 1'b0; ld_a = '0; ld_d = '0;
      test_reset();
      test_fill();
      test_copy();
      test_wrap();
      test_stall();
      test_zero_len();
      test_restart_ignored();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
